// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types, default 640x480@60 timing and pixel formatting for the VGA frame engine
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COPY,
    DRAIN,
    DISPLAY
  } fsm_t;

  localparam int VGA_H_ACT  = 640;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;
  localparam int VGA_V_ACT  = 480;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;

  localparam int MODE_GRAY   = 0;
  localparam int MODE_RGB888 = 1;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Grey mode replicates the low byte onto all three channels.
  function automatic rgb_t fmt_pixel(input logic [23:0] w, input logic rgb_mode);
    rgb_t c;
    if (rgb_mode) begin
      c.r = w[23:16];
      c.g = w[15:8];
      c.b = w[7:0];
    end else begin
      c.r = w[7:0];
      c.g = w[7:0];
      c.b = w[7:0];
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - pixel divider, h/v raster counters, raw sync/active/window flags and vgaclock
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACT      = VGA_H_ACT,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACT      = VGA_V_ACT,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int PIX_DIV    = 2,
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256,
  parameter int SCALE_LOG2 = 0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        pix_en,
  output logic [15:0] h_cnt,
  output logic [15:0] v_cnt,
  output logic        hs_act,
  output logic        vs_act,
  output logic        active,
  output logic        in_win,
  output logic        vgaclock
);

  localparam logic [7:0]  DIV_LAST = 8'(PIX_DIV - 1);
  localparam logic [7:0]  DIV_HALF = 8'(PIX_DIV / 2);
  localparam logic [15:0] H_LAST   = 16'(H_ACT + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] V_LAST   = 16'(V_ACT + V_FP + V_SYNC + V_BP - 1);
  localparam logic [15:0] H_ACT_C  = 16'(H_ACT);
  localparam logic [15:0] V_ACT_C  = 16'(V_ACT);
  localparam logic [15:0] HS_BEG   = 16'(H_ACT + H_FP);
  localparam logic [15:0] HS_END   = 16'(H_ACT + H_FP + H_SYNC);
  localparam logic [15:0] VS_BEG   = 16'(V_ACT + V_FP);
  localparam logic [15:0] VS_END   = 16'(V_ACT + V_FP + V_SYNC);
  localparam logic [15:0] WIN_W    = 16'(IMG_W << SCALE_LOG2);
  localparam logic [15:0] WIN_H    = 16'(IMG_H << SCALE_LOG2);

  logic [7:0]  div_q, div_d;
  logic [15:0] h_q, h_d;
  logic [15:0] v_q, v_d;
  logic        vgaclock_q, vgaclock_d;

  always_comb begin
    pix_en     = (div_q == DIV_LAST);
    div_d      = pix_en ? 8'd0 : div_q + 8'd1;
    // Registered from the next divider value so vgaclock falls exactly when pix_en fires.
    vgaclock_d = (div_d >= DIV_HALF);
    h_d        = h_q;
    v_d        = v_q;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d = 16'd0;
        v_d = (v_q == V_LAST) ? 16'd0 : v_q + 16'd1;
      end else begin
        h_d = h_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q      <= 8'd0;
      h_q        <= 16'd0;
      v_q        <= 16'd0;
      vgaclock_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      h_q        <= h_d;
      v_q        <= v_d;
      vgaclock_q <= vgaclock_d;
    end
  end

  assign h_cnt    = h_q;
  assign v_cnt    = v_q;
  assign hs_act   = (h_q >= HS_BEG) && (h_q < HS_END);
  assign vs_act   = (v_q >= VS_BEG) && (v_q < VS_END);
  assign active   = (h_q < H_ACT_C) && (v_q < V_ACT_C);
  assign in_win   = (h_q < WIN_W) && (v_q < WIN_H);
  assign vgaclock = vgaclock_q;

endmodule

// File: rtl/vga_frame_engine.sv
// rtl/vga_frame_engine.sv - ROM-to-RAM copy FSM plus scan fetch, 2-strobe pixel pipeline and VGA output formatting
module vga_frame_engine
  import vga_pkg::*;
#(
  parameter int          H_ACT      = VGA_H_ACT,
  parameter int          H_FP       = VGA_H_FP,
  parameter int          H_SYNC     = VGA_H_SYNC,
  parameter int          H_BP       = VGA_H_BP,
  parameter int          V_ACT      = VGA_V_ACT,
  parameter int          V_FP       = VGA_V_FP,
  parameter int          V_SYNC     = VGA_V_SYNC,
  parameter int          V_BP       = VGA_V_BP,
  parameter int          IMG_W      = 256,
  parameter int          IMG_H      = 256,
  parameter int          SCALE_LOG2 = 0,
  parameter int          PIX_DIV    = 2,
  parameter int          MODE       = MODE_GRAY,
  parameter logic [23:0] BORDER     = 24'h000000,
  parameter int          SYNC_POL   = 0,
  parameter int          ADDR_W     = 32
) (
  input  logic              clock_50,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wd,
  input  logic [31:0]       ram_rd,
  output logic              busy,
  output logic              done,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              hsync,
  output logic              vsync,
  output logic              n_blank,
  output logic              vgaclock
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] IMG_W_A   = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);

  logic        pix_en;
  logic [15:0] h_cnt, v_cnt;
  logic        hs_act, vs_act, active, in_win;

  vga_timing #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .PIX_DIV(PIX_DIV), .IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE_LOG2(SCALE_LOG2)
  ) u_timing (
    .clk(clock_50),
    .reset(reset),
    .pix_en(pix_en),
    .h_cnt(h_cnt),
    .v_cnt(v_cnt),
    .hs_act(hs_act),
    .vs_act(vs_act),
    .active(active),
    .in_win(in_win),
    .vgaclock(vgaclock)
  );

  fsm_t              state_q, state_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
  logic              hs1_q, hs1_d, vs1_q, vs1_d, act1_q, act1_d, win1_q, win1_d, disp1_q, disp1_d;
  logic              hs2_q, hs2_d, vs2_q, vs2_d, act2_q, act2_d;
  rgb_t              rgb_q, rgb_d;
  logic              unused_hi;

  assign unused_hi = ^ram_rd[31:24];

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    rom_addr = '0;
    ram_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COPY;
          n_d     = '0;
        end
      end
      COPY: begin
        // ROM has one cycle of latency, so word n-1 is written while word n is requested.
        rom_addr = n_q;
        n_d      = n_q + ONE_A;
        ram_we   = (n_q != '0);
        if (n_q == LAST_ADDR) state_d = DRAIN;
      end
      DRAIN: begin
        ram_we  = 1'b1;
        state_d = DISPLAY;
      end
      DISPLAY: begin
        if (start) begin
          state_d = COPY;
          n_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_wd = ram_we ? rom_data : 32'd0;
    if (ram_we) ram_addr = n_q - ONE_A;
    else if (state_q == DISPLAY) ram_addr = scan_addr_q;
    else ram_addr = '0;
  end

  always_comb begin
    scan_addr_d = scan_addr_q;
    hs1_d = hs1_q; vs1_d = vs1_q; act1_d = act1_q; win1_d = win1_q; disp1_d = disp1_q;
    hs2_d = hs2_q; vs2_d = vs2_q; act2_d = act2_q;
    rgb_d = rgb_q;
    if (pix_en) begin
      scan_addr_d = '0;
      if (in_win && (state_q == DISPLAY)) begin
        scan_addr_d = ADDR_W'(v_cnt >> SCALE_LOG2) * IMG_W_A + ADDR_W'(h_cnt >> SCALE_LOG2);
      end
      hs1_d   = hs_act;
      vs1_d   = vs_act;
      act1_d  = active;
      win1_d  = in_win;
      disp1_d = (state_q == DISPLAY);
      hs2_d   = hs1_q;
      vs2_d   = vs1_q;
      act2_d  = act1_q;
      // A reload between fetch and sample would put copy traffic on the bus, so both ends must be DISPLAY.
      if (!act1_q || !disp1_q || (state_q != DISPLAY)) rgb_d = '0;
      else if (!win1_q) rgb_d = rgb_t'(BORDER);
      else rgb_d = fmt_pixel(ram_rd[23:0], MODE == MODE_RGB888);
    end
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q     <= IDLE;
      n_q         <= '0;
      scan_addr_q <= '0;
      hs1_q <= 1'b0; vs1_q <= 1'b0; act1_q <= 1'b0; win1_q <= 1'b0; disp1_q <= 1'b0;
      hs2_q <= 1'b0; vs2_q <= 1'b0; act2_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      scan_addr_q <= scan_addr_d;
      hs1_q <= hs1_d; vs1_q <= vs1_d; act1_q <= act1_d; win1_q <= win1_d; disp1_q <= disp1_d;
      hs2_q <= hs2_d; vs2_q <= vs2_d; act2_q <= act2_d;
      rgb_q <= rgb_d;
    end
  end

  assign busy    = (state_q == COPY) || (state_q == DRAIN);
  assign done    = (state_q == DISPLAY);
  assign red     = rgb_q.r;
  assign green   = rgb_q.g;
  assign blue    = rgb_q.b;
  assign n_blank = act2_q;
  assign hsync   = (SYNC_POL != 0) ? hs2_q : ~hs2_q;
  assign vsync   = (SYNC_POL != 0) ? vs2_q : ~vs2_q;

endmodule

// File: tb/tb_vga_frame_engine.sv
// tb/tb_vga_frame_engine.sv - directed self-checking bench: reduced raster (16x10 totals) with grey and scaled RGB instances
module tb_vga_frame_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic start = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   edge_cnt = 0;

  logic [31:0] a_rom_addr, a_rom_data, a_ram_addr, a_ram_wd, a_ram_rd;
  logic        a_ram_we, a_busy, a_done, a_hsync, a_vsync, a_n_blank, a_vgaclock;
  logic [7:0]  a_red, a_green, a_blue;
  logic [31:0] b_rom_addr, b_rom_data, b_ram_addr, b_ram_wd, b_ram_rd;
  logic        b_ram_we, b_busy, b_done, b_hsync, b_vsync, b_n_blank, b_vgaclock;
  logic [7:0]  b_red, b_green, b_blue;

  logic [31:0] rom_a [16];
  logic [31:0] ram_a [16];
  logic [31:0] rom_b [16];
  logic [31:0] ram_b [16];

  vga_frame_engine #(
    .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACT(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .IMG_W(4), .IMG_H(4), .SCALE_LOG2(0), .PIX_DIV(2), .MODE(0), .BORDER(24'h123456),
    .SYNC_POL(0), .ADDR_W(32)
  ) dut_a (
    .clock_50(clk), .reset(reset), .start(start),
    .rom_addr(a_rom_addr), .rom_data(a_rom_data),
    .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_wd(a_ram_wd), .ram_rd(a_ram_rd),
    .busy(a_busy), .done(a_done), .red(a_red), .green(a_green), .blue(a_blue),
    .hsync(a_hsync), .vsync(a_vsync), .n_blank(a_n_blank), .vgaclock(a_vgaclock)
  );

  vga_frame_engine #(
    .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACT(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .IMG_W(4), .IMG_H(4), .SCALE_LOG2(1), .PIX_DIV(2), .MODE(1), .BORDER(24'h0000FF),
    .SYNC_POL(0), .ADDR_W(32)
  ) dut_b (
    .clock_50(clk), .reset(reset), .start(start),
    .rom_addr(b_rom_addr), .rom_data(b_rom_data),
    .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wd(b_ram_wd), .ram_rd(b_ram_rd),
    .busy(b_busy), .done(b_done), .red(b_red), .green(b_green), .blue(b_blue),
    .hsync(b_hsync), .vsync(b_vsync), .n_blank(b_n_blank), .vgaclock(b_vgaclock)
  );

  always @(posedge clk) begin
    a_rom_data <= rom_a[a_rom_addr[3:0]];
    if (a_ram_we) ram_a[a_ram_addr[3:0]] <= a_ram_wd;
    a_ram_rd <= ram_a[a_ram_addr[3:0]];
    b_rom_data <= rom_b[b_rom_addr[3:0]];
    if (b_ram_we) ram_b[b_ram_addr[3:0]] <= b_ram_wd;
    b_ram_rd <= ram_b[b_ram_addr[3:0]];
  end

  // Edges since the last reset-sampled edge; pixel p is on the outputs after edge 2p+4.
  always @(posedge clk) begin
    if (reset) edge_cnt <= 0;
    else edge_cnt <= edge_cnt + 1;
  end

  task automatic goto_hv(input int h, input int v);
    int p;
    int guard;
    @(negedge clk);
    p = v * 16 + h;
    while (2 * p + 4 < edge_cnt) p += 160;
    guard = 0;
    while (edge_cnt < 2 * p + 4 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (edge_cnt != 2 * p + 4) begin
      failures++;
      $display("FAIL goto_hv(%0d,%0d): edge %0d, required %0d", h, v, edge_cnt, 2 * p + 4);
    end
  endtask

  task automatic test_reset();
    int k, p, h, v;
    logic exp_hs, exp_vs, exp_nb;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_busy, a_done, a_ram_we, a_n_blank, a_vgaclock, a_hsync, a_vsync} !== 7'b0000011) begin
      failures++;
      $display("FAIL reset_flags: busy/done/we/nb/vclk/hs/vs=%b required 0000011",
               {a_busy, a_done, a_ram_we, a_n_blank, a_vgaclock, a_hsync, a_vsync});
    end
    checks++;
    if ({a_rom_addr, a_ram_addr, a_red, a_green, a_blue} !== 88'd0) begin
      failures++;
      $display("FAIL reset_zero: rom_addr=%0h ram_addr=%0h rgb=%02h%02h%02h required all 0",
               a_rom_addr, a_ram_addr, a_red, a_green, a_blue);
    end
    reset = 1'b0;
    for (int i = 0; i < 340; i++) begin
      if (i != 0) @(negedge clk);
      k = edge_cnt;
      if (k < 4) begin
        exp_hs = 1'b1; exp_vs = 1'b1; exp_nb = 1'b0;
      end else begin
        p = (k - 4) / 2;
        h = p % 16;
        v = (p / 16) % 10;
        exp_hs = !(h >= 10 && h < 13);
        exp_vs = !(v >= 7 && v < 9);
        exp_nb = (h < 8) && (v < 6);
      end
      checks += 5;
      if (a_hsync !== exp_hs) begin
        failures++;
        $display("FAIL idle_hsync edge %0d: got %b required %b", k, a_hsync, exp_hs);
      end
      if (a_vsync !== exp_vs) begin
        failures++;
        $display("FAIL idle_vsync edge %0d: got %b required %b", k, a_vsync, exp_vs);
      end
      if (a_n_blank !== exp_nb) begin
        failures++;
        $display("FAIL idle_n_blank edge %0d: got %b required %b", k, a_n_blank, exp_nb);
      end
      if (a_vgaclock !== k[0]) begin
        failures++;
        $display("FAIL idle_vgaclock edge %0d: got %b required %b", k, a_vgaclock, k[0]);
      end
      if ({a_red, a_green, a_blue, a_done} !== 25'd0) begin
        failures++;
        $display("FAIL idle_rgb_done edge %0d: rgb=%02h%02h%02h done=%b required 0",
                 k, a_red, a_green, a_blue, a_done);
      end
    end
  endtask

  task automatic test_copy();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c <= 17; c++) begin
      if (c != 0) @(negedge clk);
      checks += 3;
      if (a_busy !== (c <= 16)) begin
        failures++;
        $display("FAIL copy_busy c=%0d: got %b required %b", c, a_busy, c <= 16);
      end
      if (a_done !== (c == 17)) begin
        failures++;
        $display("FAIL copy_done c=%0d: got %b required %b", c, a_done, c == 17);
      end
      if (a_ram_we !== (c >= 1 && c <= 16)) begin
        failures++;
        $display("FAIL copy_we c=%0d: got %b required %b", c, a_ram_we, c >= 1 && c <= 16);
      end
      if (c >= 1 && c <= 16) begin
        checks++;
        if (a_ram_addr !== 32'(c - 1) || a_ram_wd !== 32'((c - 1) * 16)) begin
          failures++;
          $display("FAIL copy_write c=%0d: addr=%0d wd=%0h required addr=%0d wd=%0h",
                   c, a_ram_addr, a_ram_wd, c - 1, (c - 1) * 16);
        end
      end
      if (c <= 15) begin
        checks++;
        if (a_rom_addr !== 32'(c)) begin
          failures++;
          $display("FAIL copy_rom_addr c=%0d: got %0d required %0d", c, a_rom_addr, c);
        end
      end
    end
    checks++;
    if (b_done !== 1'b1 || b_busy !== 1'b0) begin
      failures++;
      $display("FAIL copy_b_done: done=%b busy=%b required 1 0", b_done, b_busy);
    end
    for (int i = 0; i < 16; i++) begin
      checks += 2;
      if (ram_a[i] !== 32'(i * 16)) begin
        failures++;
        $display("FAIL ram_a[%0d]: got %0h required %0h", i, ram_a[i], i * 16);
      end
      if (ram_b[i] !== rom_b[i]) begin
        failures++;
        $display("FAIL ram_b[%0d]: got %0h required %0h", i, ram_b[i], rom_b[i]);
      end
    end
  endtask

  task automatic test_grey_display();
    int          th [10] = '{1, 0, 3, 2, 4, 0, 7, 8, 11, 3};
    int          tv [10] = '{0, 0, 3, 3, 0, 4, 5, 0, 2, 7};
    logic [23:0] trgb [10] = '{24'h101010, 24'h000000, 24'hF0F0F0, 24'hE0E0E0, 24'h123456,
                               24'h123456, 24'h123456, 24'h000000, 24'h000000, 24'h000000};
    logic [2:0]  tflg [10] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111,
                               3'b111, 3'b111, 3'b011, 3'b001, 3'b010};
    for (int i = 0; i < 10; i++) begin
      goto_hv(th[i], tv[i]);
      checks += 2;
      if ({a_red, a_green, a_blue} !== trgb[i]) begin
        failures++;
        $display("FAIL grey_rgb (%0d,%0d): got %02h%02h%02h required %06h",
                 th[i], tv[i], a_red, a_green, a_blue, trgb[i]);
      end
      if ({a_n_blank, a_hsync, a_vsync} !== tflg[i]) begin
        failures++;
        $display("FAIL grey_flags (%0d,%0d): nb/hs/vs=%b required %b",
                 th[i], tv[i], {a_n_blank, a_hsync, a_vsync}, tflg[i]);
      end
    end
  endtask

  task automatic test_scale_rgb();
    int          th [8] = '{0, 1, 0, 1, 2, 7, 3, 9};
    int          tv [8] = '{0, 0, 1, 1, 0, 5, 2, 0};
    logic [23:0] trgb [8] = '{24'h102030, 24'h102030, 24'h102030, 24'h102030,
                              24'h112131, 24'h1B2B3B, 24'h152535, 24'h000000};
    logic        tnb [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      goto_hv(th[i], tv[i]);
      checks += 2;
      if ({b_red, b_green, b_blue} !== trgb[i]) begin
        failures++;
        $display("FAIL scale_rgb (%0d,%0d): got %02h%02h%02h required %06h",
                 th[i], tv[i], b_red, b_green, b_blue, trgb[i]);
      end
      if (b_n_blank !== tnb[i]) begin
        failures++;
        $display("FAIL scale_nb (%0d,%0d): got %b required %b", th[i], tv[i], b_n_blank, tnb[i]);
      end
    end
  endtask

  task automatic test_reload();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c <= 17; c++) begin
      if (c != 0) @(negedge clk);
      start = (c == 4);
      checks += 2;
      if (a_done !== (c == 17)) begin
        failures++;
        $display("FAIL reload_done c=%0d: got %b required %b", c, a_done, c == 17);
      end
      if (a_busy !== (c <= 16)) begin
        failures++;
        $display("FAIL reload_busy c=%0d: got %b required %b", c, a_busy, c <= 16);
      end
      if (c == 16) begin
        checks++;
        if (a_ram_we !== 1'b1 || a_ram_addr !== 32'd15) begin
          failures++;
          $display("FAIL reload_last_write: we=%b addr=%0d required 1 15", a_ram_we, a_ram_addr);
        end
      end
    end
    start = 1'b0;
    goto_hv(2, 1);
    checks++;
    if ({a_red, a_green, a_blue} !== 24'h606060) begin
      failures++;
      $display("FAIL reload_pixel (2,1): got %02h%02h%02h required 606060", a_red, a_green, a_blue);
    end
  endtask

  task automatic test_mid_copy_reset();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      if (c != 0) @(negedge clk);
      if (c == 7) begin
        checks++;
        if (a_rom_addr !== 32'd7) begin
          failures++;
          $display("FAIL midreset_rom_addr: got %0d required 7", a_rom_addr);
        end
        reset = 1'b1;
      end
    end
    checks++;
    if ({a_busy, a_done, a_ram_we} !== 3'b000 || a_rom_addr !== 32'd0) begin
      failures++;
      $display("FAIL midreset_state: busy/done/we=%b rom_addr=%0d required 000 0",
               {a_busy, a_done, a_ram_we}, a_rom_addr);
    end
    @(negedge clk) reset = 1'b0;
    test_copy();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      rom_a[i] = 32'(i * 16);
      rom_b[i] = {8'hA5, 8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i)};
    end
    test_reset();
    test_copy();
    test_grey_display();
    test_scale_rgb();
    test_reload();
    test_mid_copy_reset();
    test_grey_display();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
